uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ------------
// Receive buffer that sits directly behind the UART receiver. It captures each
// byte the receiver presents with a one-cycle strobe and holds up to DEPTH
// bytes. The register interface sees the bytes as a first-word-fall-through
// queue: the head byte is always visible on rd_data_out, and rd_en_in pops it.
// The block tracks the fill level, sets a sticky overrun flag when a byte
// arrives while the buffer is full, and raises a level/overrun interrupt.
//
// Handshake: there is no back-pressure towards the receiver. A byte is
// offered for exactly one cycle by rx_data_valid_in=1. It is accepted when
// the buffer has room, or when a pop happens in the same cycle. Otherwise it
// is dropped and overrun_out is set. On the read side, rd_en_in=1 pops the
// head entry at the clock edge, but only when the buffer is not empty.
// A pop request on an empty buffer is ignored silently.
//
// Ports
//   clk_in            system clock, rising edge
//   reset_in          asynchronous active-low reset
//   rx_data_in        received byte
//   rx_data_valid_in  one-cycle strobe qualifying rx_data_in
//   rd_en_in          pop head entry at this edge
//   rd_data_out       head entry, 8'h00 while empty
//   empty_out         no entries stored
//   full_out          DEPTH entries stored
//   level_out         entry count, 0..DEPTH
//   overrun_out       sticky, set when a byte was dropped
//   overrun_clr_in    clears overrun_out (a set in the same cycle wins)
//   irq_out           (level_out >= THRESHOLD) | overrun_out
//
// DEPTH must be a power of two (>= 2) so that the pointers wrap naturally.

module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 8
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic [7:0]                 rx_data_in,
  input  logic                       rx_data_valid_in,
  input  logic                       rd_en_in,
  output logic [7:0]                 rd_data_out,
  output logic                       empty_out,
  output logic                       full_out,
  output logic [$clog2(DEPTH+1)-1:0] level_out,
  output logic                       overrun_out,
  input  logic                       overrun_clr_in,
  output logic                       irq_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [LW-1:0] count;
  logic          overrun;

  logic is_empty;
  logic is_full;
  logic do_pop;
  logic do_write;
  logic drop;

  assign is_empty = (count == '0);
  assign is_full  = (count == LW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full buffer still accepts
  // a byte when it is popped at the same edge.
  assign do_pop   = rd_en_in && !is_empty;
  assign do_write = rx_data_valid_in && (!is_full || do_pop);
  assign drop     = rx_data_valid_in && !do_write;

  // Array contents are never reset. After a reset, count=0 makes any stale
  // data unreachable.
  always_ff @(posedge clk_in) begin
    if (do_write) begin
      mem[wp] <= rx_data_in;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_write) begin
        wp <= wp + AW'(1);
      end
      if (do_pop) begin
        rp <= rp + AW'(1);
      end
      if (do_write && !do_pop) begin
        count <= count + LW'(1);
      end else if (do_pop && !do_write) begin
        count <= count - LW'(1);
      end
      // A new drop wins over a clear in the same cycle.
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr_in) begin
        overrun <= 1'b0;
      end
    end
  end

  // Every output depends only on registered state (count, rp, mem, overrun).
  assign rd_data_out = is_empty ? 8'h00 : mem[rp];
  assign empty_out   = is_empty;
  assign full_out    = is_full;
  assign level_out   = count;
  assign overrun_out = overrun;
  assign irq_out     = (count >= LW'(THRESHOLD)) || overrun;

endmodule
